// File: rtl/seq_mult_div.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_div
// Brief    : Sequential signed multiply (radix-2 Booth) / divide (restoring)
//            unit producing HI/LO results over WIDTH iterations.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mult_div #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [CW-1:0]    count;
    logic             op_r, neg_q, neg_r, qm1;
    logic [WIDTH-1:0] mcand, acc_hi, acc_lo;

    logic             accept, b_zero, last;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] step_hi, step_lo, res_hi, res_lo;
    logic             step_qm1;

    assign accept = (state == S_IDLE) && start;
    assign b_zero = (b == '0);
    assign last   = (count == '0);
    assign a_mag  = a[WIDTH-1] ? ('0 - a) : a;
    assign b_mag  = b[WIDTH-1] ? ('0 - b) : b;

    // One iteration: Booth add/sub with a sign-extended sum so the arithmetic
    // shift stays exact even for the most negative multiplicand.
    always_comb begin
        booth_sum = {acc_hi[WIDTH-1], acc_hi};
        div_trial = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_trial[WIDTH-1:0] - mcand;
        step_hi   = acc_hi;
        step_lo   = acc_lo;
        step_qm1  = qm1;
        if (!op_r) begin
            case ({acc_lo[0], qm1})
                2'b01:   booth_sum = {acc_hi[WIDTH-1], acc_hi} + {mcand[WIDTH-1], mcand};
                2'b10:   booth_sum = {acc_hi[WIDTH-1], acc_hi} - {mcand[WIDTH-1], mcand};
                default: booth_sum = {acc_hi[WIDTH-1], acc_hi};
            endcase
            step_hi  = booth_sum[WIDTH:1];
            step_lo  = {booth_sum[0], acc_lo[WIDTH-1:1]};
            step_qm1 = acc_lo[0];
        end else if (div_trial >= {1'b0, mcand}) begin
            step_hi = div_diff;
            step_lo = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            step_hi = div_trial[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

    assign res_hi = (op_r && neg_r) ? ('0 - step_hi) : step_hi;
    assign res_lo = (op_r && neg_q) ? ('0 - step_lo) : step_lo;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = (op && b_zero) ? S_DONE : S_RUN;
            S_RUN:   if (last) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count       <= '0;
            op_r        <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            qm1         <= 1'b0;
            mcand       <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            op_r        <= op;
            count       <= CW'(WIDTH - 1);
            div_by_zero <= op && b_zero;
            acc_hi      <= '0;
            qm1         <= 1'b0;
            if (op) begin
                mcand  <= b_mag;
                acc_lo <= a_mag;
                neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                neg_r  <= a[WIDTH-1];
            end else begin
                mcand  <= a;
                acc_lo <= b;
                neg_q  <= 1'b0;
                neg_r  <= 1'b0;
            end
        end else if (state == S_RUN) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            qm1    <= step_qm1;
            if (last) begin
                hi <= res_hi;
                lo <= res_lo;
            end else begin
                count <= count - CW'(1);
            end
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_div.sv
`default_nettype none
// Scoreboard bench for seq_mult_div: directed vectors queue expected HI/LO/flag,
// a negedge monitor pops and compares on every done pulse.
module tb_seq_mult_div;
    logic        clock;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a, b;
    logic [31:0] hi, lo;
    logic        busy, done, div_by_zero;

    int vectors;
    int miscompares;
    logic [64:0] exp_q[$];

    seq_mult_div #(.WIDTH(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (!reset && done) begin
            logic [64:0] e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done: hi=%h lo=%h dbz=%b with nothing outstanding", hi, lo, div_by_zero);
            end else begin
                e = exp_q.pop_front();
                if ({div_by_zero, hi, lo} !== e)
                    begin
                        miscompares++;
                        $display("FAIL result: got dbz=%b hi=%h lo=%h, expected dbz=%b hi=%h lo=%h",
                                 div_by_zero, hi, lo, e[64], e[63:32], e[31:0]);
                    end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edbz, input bit inject);
        int n;
        @(negedge clock);
        start = 1'b1; op = o; a = x; b = y;
        exp_q.push_back({edbz, ehi, elo});
        @(posedge clock); #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        check("busy_after_accept", 64'(busy), 64'(!edbz));
        check("dbz_after_accept", 64'(div_by_zero), 64'(edbz));
        n = 0;
        while (!done && n < 40) begin
            if (inject && n == 4) begin
                start = 1'b1; op = 1'b0; a = 32'd9; b = 32'd9;
            end
            @(posedge clock); #1;
            n++;
            start = 1'b0;
        end
        check("done_latency", 64'(n), edbz ? 64'd0 : 64'd32);
        check("busy_in_done", 64'(busy), 64'd0);
        if (inject) start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("done_is_one_cycle", 64'(done), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        check("held_result", {hi, lo}, {ehi, elo});
        check("dbz_held", 64'(div_by_zero), 64'(edbz));
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_state", {28'd0, busy, done, div_by_zero, 1'b0, 32'd0} | {hi, lo}, 64'd0);
        @(negedge clock) reset = 1'b0;

        run_op(1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
        run_op(1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0);
        run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0);
        run_op(1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
        run_op(1'b1, 32'h00000451, 32'h00000020, 32'h00000011, 32'h00000022, 1'b0, 1'b0);
        run_op(1'b1, 32'h00001234, 32'd0,        32'h00000011, 32'h00000022, 1'b1, 1'b0);
        run_op(1'b0, 32'd5,        32'd6,        32'h00000000, 32'd30,       1'b0, 1'b1);

        // Asynchronous reset part-way through a MULT.
        @(negedge clock);
        start = 1'b1; op = 1'b0; a = 32'd12345; b = 32'd6789;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        check("async_reset_hilo", {hi, lo}, 64'd0);
        check("async_reset_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        @(negedge clock) reset = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        check("no_op_after_reset", 64'(busy), 64'd0);

        run_op(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
